// File: rtl/aes_spi_scheduler.sv
// Two-requester scheduler for an external AES engine pair reached over SPI:
// it grants one request, shifts data and key out, waits a gap, and shifts the result back in.
module aes_spi_scheduler #(
  parameter int GAP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         req_b,
  input  logic         mode_a,
  input  logic         mode_b,
  input  logic [1:0]   nk_a,
  input  logic [1:0]   nk_b,
  input  logic [127:0] data_a,
  input  logic [127:0] data_b,
  input  logic [255:0] key_a,
  input  logic [255:0] key_b,
  output logic         ack_a,
  output logic         ack_b,
  output logic         done_a,
  output logic         done_b,
  output logic [127:0] result,
  output logic         busy,
  output logic         sdo,
  input  logic         sdi,
  output logic         cs_enc_n,
  output logic         cs_dec_n
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_DATA = 3'd1;
  localparam logic [2:0] ST_SEND_KEY  = 3'd2;
  localparam logic [2:0] ST_GAP       = 3'd3;
  localparam logic [2:0] ST_RECV      = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  localparam logic       HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [8:0] GAP_LAST = HAS_GAP ? 9'(GAP_CYCLES - 1) : 9'd0;

  logic [2:0]   r_state;
  logic [8:0]   r_cnt;
  logic [8:0]   r_klast;
  logic [127:0] r_data;
  logic [255:0] r_key;
  logic [126:0] r_rx;
  logic         r_owner_b;
  logic         r_last_b;

  logic         w_grant;
  logic         w_grant_b;
  logic         w_sel_mode;
  logic [1:0]   w_sel_nk;
  logic [127:0] w_sel_data;
  logic [255:0] w_sel_key;
  logic [8:0]   w_klast;

  // Round-robin arbitration and selection of the winner's inputs.
  always_comb begin
    w_grant   = 1'b0;
    w_grant_b = 1'b0;
    if (req_a && req_b) begin
      w_grant   = 1'b1;
      w_grant_b = ~r_last_b;
    end else if (req_a) begin
      w_grant   = 1'b1;
      w_grant_b = 1'b0;
    end else if (req_b) begin
      w_grant   = 1'b1;
      w_grant_b = 1'b1;
    end else begin
      w_grant   = 1'b0;
      w_grant_b = 1'b0;
    end

    w_sel_mode = w_grant_b ? mode_b : mode_a;
    w_sel_nk   = w_grant_b ? nk_b   : nk_a;
    w_sel_data = w_grant_b ? data_b : data_a;
    w_sel_key  = w_grant_b ? key_b  : key_a;

    case (w_sel_nk)
      2'b00:   w_klast = 9'd127;
      2'b01:   w_klast = 9'd191;
      default: w_klast = 9'd255;
    endcase
  end

  // Transaction sequencer; r_cnt holds the cycles left in the current state minus one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 9'd0;
      r_klast   <= 9'd0;
      r_data    <= '0;
      r_key     <= '0;
      r_rx      <= '0;
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;
      result    <= '0;
      busy      <= 1'b0;
      sdo       <= 1'b0;
      cs_enc_n  <= 1'b1;
      cs_dec_n  <= 1'b1;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
    end else begin
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state   <= ST_SEND_DATA;
            r_cnt     <= 9'd127;
            r_klast   <= w_klast;
            r_data    <= {w_sel_data[126:0], 1'b0};
            r_key     <= w_sel_key;
            r_owner_b <= w_grant_b;
            r_last_b  <= w_grant_b;
            ack_a     <= ~w_grant_b;
            ack_b     <= w_grant_b;
            busy      <= 1'b1;
            sdo       <= w_sel_data[127];
            cs_enc_n  <= ~w_sel_mode;
            cs_dec_n  <= w_sel_mode;
          end
        end
        ST_SEND_DATA: begin
          if (r_cnt == 9'd0) begin
            r_state <= ST_SEND_KEY;
            r_cnt   <= r_klast;
            sdo     <= r_key[255];
            r_key   <= {r_key[254:0], 1'b0};
          end else begin
            r_cnt  <= r_cnt - 9'd1;
            sdo    <= r_data[127];
            r_data <= {r_data[126:0], 1'b0};
          end
        end
        ST_SEND_KEY: begin
          if (r_cnt == 9'd0) begin
            sdo <= 1'b0;
            if (HAS_GAP) begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LAST;
            end else begin
              r_state <= ST_RECV;
              r_cnt   <= 9'd127;
            end
          end else begin
            r_cnt <= r_cnt - 9'd1;
            sdo   <= r_key[255];
            r_key <= {r_key[254:0], 1'b0};
          end
        end
        ST_GAP: begin
          sdo <= 1'b0;
          if (r_cnt == 9'd0) begin
            r_state <= ST_RECV;
            r_cnt   <= 9'd127;
          end else begin
            r_cnt <= r_cnt - 9'd1;
          end
        end
        ST_RECV: begin
          r_rx <= {r_rx[125:0], sdi};
          // result only moves once the full block is in, never on partial shifts
          if (r_cnt == 9'd0) begin
            r_state  <= ST_DONE;
            result   <= {r_rx, sdi};
            done_a   <= ~r_owner_b;
            done_b   <= r_owner_b;
            cs_enc_n <= 1'b1;
            cs_dec_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 9'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          sdo     <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          busy     <= 1'b0;
          sdo      <= 1'b0;
          cs_enc_n <= 1'b1;
          cs_dec_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_scheduler.sv
// Self-checking bench for aes_spi_scheduler: directed scenarios plus randomized
// transactions compared against a bit-stream model of the serial protocol.
module tb_aes_spi_scheduler;
  localparam int GAP = 4;

  localparam logic [127:0] FIPS_DATA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] FIPS_RES  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0, mode_a = 1'b0, mode_b = 1'b0;
  logic [1:0]   nk_a = 2'b00, nk_b = 2'b00;
  logic [127:0] data_a = '0, data_b = '0;
  logic [255:0] key_a = '0, key_b = '0;
  logic         sdi = 1'b0;
  logic         ack_a, ack_b, done_a, done_b, busy, sdo, cs_enc_n, cs_dec_n;
  logic [127:0] result;

  int           n_cmp = 0;
  int           n_err = 0;
  logic         m_last_b = 1'b1;
  logic [127:0] m_result = '0;

  aes_spi_scheduler #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .mode_a(mode_a), .mode_b(mode_b),
    .nk_a(nk_a), .nk_b(nk_b), .data_a(data_a), .data_b(data_b),
    .key_a(key_a), .key_b(key_b),
    .ack_a(ack_a), .ack_b(ack_b), .done_a(done_a), .done_b(done_b),
    .result(result), .busy(busy), .sdo(sdo), .sdi(sdi),
    .cs_enc_n(cs_enc_n), .cs_dec_n(cs_dec_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %032h expected %032h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int k_of(input logic [1:0] nk);
    return (nk == 2'b00) ? 128 : (nk == 2'b01) ? 192 : 256;
  endfunction

  // Expected MOSI bit n cycles after the grant edge: data, then K key bits, then zeros.
  function automatic logic exp_bit(input int n, input logic [127:0] d, input logic [255:0] k, input int kl);
    if (n < 128) return d[127-n];
    else if (n < 128 + kl) return k[255-(n-128)];
    else return 1'b0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic set_req(input logic who_b, input logic mode, input logic [1:0] nk,
                         input logic [127:0] data, input logic [255:0] key);
    if (who_b) begin
      req_b = 1'b1; mode_b = mode; nk_b = nk; data_b = data; key_b = key;
    end else begin
      req_a = 1'b1; mode_a = mode; nk_a = nk; data_a = data; key_a = key;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_sdo"}, sdo, 1'b0);
    chk1({tag, "_cs_enc_n"}, cs_enc_n, 1'b1);
    chk1({tag, "_cs_dec_n"}, cs_dec_n, 1'b1);
    chk128({tag, "_result"}, result, 128'h0);
    chk1({tag, "_ack_a"}, ack_a, 1'b0);
    chk1({tag, "_ack_b"}, ack_b, 1'b0);
    chk1({tag, "_done_a"}, done_a, 1'b0);
    chk1({tag, "_done_b"}, done_b, 1'b0);
  endtask

  // Called in an idle cycle; returns in the idle cycle after DONE (or after a reset abort).
  task automatic do_txn(input logic who_b, input logic mode, input logic [1:0] nk,
                        input logic [127:0] data, input logic [255:0] key, input logic [127:0] resp,
                        input int abort_at, input bit pulse_other);
    int kl, total, r, sdo_err, cs_low, ack_err, stat_err, res_err;
    logic cs_sel, cs_oth;
    kl = k_of(nk);
    total = 256 + kl + GAP;
    sdo_err = 0; cs_low = 0; ack_err = 0; stat_err = 0; res_err = 0;
    set_req(who_b, mode, nk, data, key);
    tick();
    // inputs change after the ack; the latched copy must be used
    if (who_b) begin
      req_b = 1'b0; mode_b = ~mode; nk_b = ~nk; data_b = rnd128(); key_b = rnd256();
    end else begin
      req_a = 1'b0; mode_a = ~mode; nk_a = ~nk; data_a = rnd128(); key_a = rnd256();
    end
    for (int n = 0; n < total; n++) begin
      if (n == abort_at) begin
        chki("pre_abort_sdo_errs", sdo_err, 0);
        chki("pre_abort_cs_cycles", cs_low, n);
        rst = 1'b0;
        #1;
        m_result = '0;
        m_last_b = 1'b1;
        chk_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
          tick();
          chk1("abort_no_done", done_a | done_b, 1'b0);
        end
        rst = 1'b1;
        tick();
        chk1("abort_idle_busy", busy, 1'b0);
        chk1("abort_idle_done", done_a | done_b, 1'b0);
        return;
      end
      if (n < 128 + kl + GAP && sdo !== exp_bit(n, data, key, kl)) sdo_err++;
      cs_sel = mode ? cs_enc_n : cs_dec_n;
      cs_oth = mode ? cs_dec_n : cs_enc_n;
      if (cs_sel === 1'b0 && cs_oth === 1'b1) cs_low++;
      if (ack_a !== (n == 0 && !who_b) || ack_b !== (n == 0 && who_b)) ack_err++;
      if (done_a !== 1'b0 || done_b !== 1'b0 || busy !== 1'b1) stat_err++;
      if (result !== m_result) res_err++;
      r = n - (128 + kl + GAP);
      sdi = (r >= 0) ? resp[127-r] : 1'($urandom_range(0, 1));
      if (pulse_other && n == 10) begin
        if (who_b) req_a = 1'b1; else req_b = 1'b1;
      end
      if (pulse_other && n == 30) begin
        if (who_b) req_a = 1'b0; else req_b = 1'b0;
      end
      tick();
    end
    m_result = resp;
    m_last_b = who_b;
    chki("sdo_stream_errs", sdo_err, 0);
    chki("cs_low_cycles", cs_low, total);
    chki("ack_pulse_errs", ack_err, 0);
    chki("busy_done_errs", stat_err, 0);
    chki("result_hold_errs", res_err, 0);
    chk1("done_a", done_a, !who_b);
    chk1("done_b", done_b, who_b);
    chk128("result", result, m_result);
    chk1("done_cs_enc_n", cs_enc_n, 1'b1);
    chk1("done_cs_dec_n", cs_dec_n, 1'b1);
    chk1("done_sdo", sdo, 1'b0);
    chk1("done_busy", busy, 1'b1);
    tick();
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_done", done_a | done_b, 1'b0);
    chk128("idle_result", result, m_result);
  endtask

  initial begin
    logic         rm [2];
    logic [1:0]   rnk [2];
    logic [127:0] rd [2];
    logic [255:0] rk [2];
    logic [127:0] rr [2];
    logic         wb;
    int           pat;

    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Tie straight after reset: A wins, B follows, another tie goes to A.
    set_req(1'b1, 1'b0, 2'b01, 128'hfedcba98765432100123456789abcdef,
            256'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebfc0c1c2c3c4c5c6c7_d8d9dadbdcdddedf);
    do_txn(1'b0, 1'b1, 2'b00, FIPS_DATA, FIPS_KEY, FIPS_RES, -1, 1'b0);
    do_txn(1'b1, 1'b0, 2'b01, 128'hfedcba98765432100123456789abcdef,
           256'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebfc0c1c2c3c4c5c6c7_d8d9dadbdcdddedf,
           128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, -1, 1'b0);
    set_req(1'b1, 1'b1, 2'b00, rnd128(), rnd256());
    do_txn(1'b0, 1'b1, 2'b11, rnd128(), rnd256(), rnd128(), -1, 1'b0);
    req_b = 1'b0;
    tick();
    chk1("dropped_req_b_ack", ack_b, 1'b0);
    chk1("dropped_req_b_busy", busy, 1'b0);

    // B requests while A is busy and withdraws before IDLE.
    do_txn(1'b0, 1'b0, 2'b10, rnd128(), rnd256(), rnd128(), -1, 1'b1);
    tick();
    chk1("pulsed_req_b_ack", ack_b, 1'b0);
    chk1("pulsed_req_b_busy", busy, 1'b0);

    // Randomized traffic; ties resolved by the round-robin model.
    for (int it = 0; it < 5; it++) begin
      for (int s = 0; s < 2; s++) begin
        rm[s] = 1'($urandom_range(0, 1));
        rnk[s] = 2'($urandom_range(0, 3));
        rd[s] = rnd128();
        rk[s] = rnd256();
        rr[s] = rnd128();
      end
      pat = $urandom_range(1, 3);
      wb = (pat == 3) ? ~m_last_b : (pat == 2);
      if (pat == 3) set_req(~wb, rm[~wb], rnk[~wb], rd[~wb], rk[~wb]);
      do_txn(wb, rm[wb], rnk[wb], rd[wb], rk[wb], rr[wb], -1, 1'b0);
      if (pat == 3) do_txn(~wb, rm[~wb], rnk[~wb], rd[~wb], rk[~wb], rr[~wb], -1, 1'b0);
    end

    // Reset in the middle of SEND_KEY, then a clean transaction.
    do_txn(1'b0, 1'b1, 2'b00, rnd128(), rnd256(), rnd128(), 128 + 50, 1'b0);
    do_txn(1'b0, 1'b1, 2'b00, FIPS_DATA, FIPS_KEY, FIPS_RES, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
